// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: N valid/ready inputs, one registered output.
// master = producer/consumer side, slave = the mux itself.
interface arb_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/arb_mux.sv
// Registered N-channel valid/ready mux, fixed-select or round-robin grant.
// ARB_MUX_STATS_EN adds xfer_count and drop_sel ports.
module arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  arb_mux_if.slave bus
`ifdef ARB_MUX_STATS_EN
  ,
  output logic [15:0] xfer_count,
  output logic [0:0]  drop_sel
`endif
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   cand;
  logic             gnt_any;
  logic             load_en;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] gnt_word;

  // Pick the winning channel: explicit select or first valid from rr_q up
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!bus.mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cand = {1'b0, rr_q} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(CHANNELS))
          cand = cand - (SEL_W+1)'(CHANNELS);
        if (!gnt_any && bus.in_valid[cand[SEL_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  assign gnt_word = bus.in_data[gnt_idx*WIDTH +: WIDTH];
  assign load_en  = (state_q == S_EMPTY) || bus.out_ready;
  assign in_xfer  = load_en && gnt_any;
  assign out_xfer = (state_q == S_FULL) && bus.out_ready;

  // Next state: load on input transfer, else drain on output transfer
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    chan_d  = chan_q;
    rr_d    = rr_q;
    if (in_xfer) begin
      state_d = S_FULL;
      data_d  = gnt_word;
      chan_d  = gnt_idx;
      rr_d    = (int'(gnt_idx) == CHANNELS-1) ? '0 : gnt_idx + 1'b1;
    end else if (out_xfer) begin
      state_d = S_EMPTY;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      rr_q    <= rr_d;
    end
  end

  // Drive handshake outputs; in_ready is held low while in reset
  always_comb begin
    bus.in_ready = '0;
    if (reset_n && in_xfer)
      bus.in_ready = CHANNELS'(1) << gnt_idx;
    bus.out_valid = (state_q == S_FULL);
    bus.out_data  = data_q;
    bus.out_chan  = chan_q;
  end

`ifdef ARB_MUX_STATS_EN
  logic [15:0] cnt_q;
  logic        drop_q;

  // Saturating output-transfer count and sticky illegal-select flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (out_xfer && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
      if (!bus.mode && int'(bus.sel) >= CHANNELS)
        drop_q <= 1'b1;
    end
  end

  assign xfer_count = cnt_q;
  assign drop_sel   = drop_q;
`endif
endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: a 4-channel and a 3-channel instance
// share one stimulus stream, each checked against its own model.
module tb_arb_mux;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [7:0] d [4];
  logic [3:0] v;
  logic       mode;
  logic [1:0] sel;
  logic       ordy;

  arb_mux_if #(.WIDTH(8), .CHANNELS(4)) bus4 ();
  arb_mux_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();

  assign bus4.in_data   = {d[3], d[2], d[1], d[0]};
  assign bus4.in_valid  = v;
  assign bus4.mode      = mode;
  assign bus4.sel       = sel;
  assign bus4.out_ready = ordy;
  assign bus3.in_data   = {d[2], d[1], d[0]};
  assign bus3.in_valid  = v[2:0];
  assign bus3.mode      = mode;
  assign bus3.sel       = sel;
  assign bus3.out_ready = ordy;

`ifdef ARB_MUX_STATS_EN
  logic [15:0] xc [2];
  logic [0:0]  ds [2];
`endif

  arb_mux #(.WIDTH(8), .CHANNELS(4)) u4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
`ifdef ARB_MUX_STATS_EN
    , .xfer_count(xc[0]), .drop_sel(ds[0])
`endif
  );

  arb_mux #(.WIDTH(8), .CHANNELS(3)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3)
`ifdef ARB_MUX_STATS_EN
    , .xfer_count(xc[1]), .drop_sel(ds[1])
`endif
  );

  logic [3:0] rdy [2];
  logic       ov  [2];
  logic [7:0] od  [2];
  logic [1:0] oc  [2];
  assign rdy[0] = bus4.in_ready;
  assign rdy[1] = {1'b0, bus3.in_ready};
  assign ov[0]  = bus4.out_valid;
  assign ov[1]  = bus3.out_valid;
  assign od[0]  = bus4.out_data;
  assign od[1]  = bus3.out_data;
  assign oc[0]  = bus4.out_chan;
  assign oc[1]  = bus3.out_chan;

  int         nch  [2] = '{4, 3};
  string      nm   [2] = '{"c4", "c3"};
  logic       full_m [2];
  int         rr_m   [2];
  int         cnt_m  [2];
  logic       drop_m [2];
  logic       gv_m   [2];
  int         g_m    [2];
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      full_m[k] = 1'b0;
      rr_m[k]   = 0;
      cnt_m[k]  = 0;
      drop_m[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic calc_grant(input int k);
    gv_m[k] = 1'b0;
    g_m[k]  = 0;
    if (!mode) begin
      if (int'(sel) < nch[k] && v[sel]) begin
        gv_m[k] = 1'b1;
        g_m[k]  = int'(sel);
      end
    end else begin
      for (int i = 0; i < nch[k]; i++) begin
        int c;
        c = (rr_m[k] + i) % nch[k];
        if (!gv_m[k] && v[c]) begin
          gv_m[k] = 1'b1;
          g_m[k]  = c;
        end
      end
    end
  endtask

  task automatic step();
    logic       ld;
    logic       inx;
    logic       outx;
    logic [3:0] er;
    logic [9:0] fr;
    int         qs;
    #1;
    for (int k = 0; k < 2; k++) begin
      calc_grant(k);
      ld = !full_m[k] || ordy;
      er = (ld && gv_m[k]) ? (4'b0001 << g_m[k]) : 4'b0000;
      check({nm[k], " in_ready"}, 32'(rdy[k]), 32'(er));
      check({nm[k], " out_valid"}, 32'(ov[k]), 32'(full_m[k]));
      if (full_m[k]) begin
        qs = (k == 0) ? q0.size() : q1.size();
        check({nm[k], " sb_depth"}, qs, 1);
        if (qs > 0) begin
          fr = (k == 0) ? q0[0] : q1[0];
          check({nm[k], " out_data"}, 32'(od[k]), 32'(fr[7:0]));
          check({nm[k], " out_chan"}, 32'(oc[k]), 32'(fr[9:8]));
        end
      end
`ifdef ARB_MUX_STATS_EN
      check({nm[k], " xfer_count"}, 32'(xc[k]), cnt_m[k]);
      check({nm[k], " drop_sel"}, 32'(ds[k]), 32'(drop_m[k]));
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ld   = !full_m[k] || ordy;
      outx = full_m[k] && ordy;
      inx  = ld && gv_m[k];
      if (outx) begin
        if (k == 0 && q0.size() > 0) void'(q0.pop_front());
        if (k == 1 && q1.size() > 0) void'(q1.pop_front());
        if (cnt_m[k] < 16'hFFFF) cnt_m[k]++;
      end
      if (inx) begin
        if (k == 0) q0.push_back({2'(g_m[k]), d[g_m[k]]});
        else        q1.push_back({2'(g_m[k]), d[g_m[k]]});
        rr_m[k] = (g_m[k] + 1) % nch[k];
      end
      full_m[k] = inx || (full_m[k] && !ordy);
      if (!mode && int'(sel) >= nch[k]) drop_m[k] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int c = 0; c < 4; c++) d[c] = 8'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    v       = 4'hF;
    mode    = 1'b1;
    sel     = 2'd0;
    ordy    = 1'b1;
    for (int c = 0; c < 4; c++) d[c] = 8'(c);
    model_reset();

    #12;
    for (int k = 0; k < 2; k++) begin
      check({nm[k], " rst in_ready"}, 32'(rdy[k]), 0);
      check({nm[k], " rst out_valid"}, 32'(ov[k]), 0);
      check({nm[k], " rst out_data"}, 32'(od[k]), 0);
      check({nm[k], " rst out_chan"}, 32'(oc[k]), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    mode = 1'b0;
    sel  = 2'd0;
    v    = 4'b0011;
    d[0] = 8'h00;
    d[1] = 8'h01;
    step();
    sel  = 2'd1;
    d[0] = 8'h01;
    d[1] = 8'h02;
    step();
    step();
    check("c4 fixed sel1 data", 32'(od[0]), 32'h02);

    mode = 1'b1;
    v    = 4'hF;
    rand_data();
    step();
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check({nm[k], " midrst out_valid"}, 32'(ov[k]), 0);
      check({nm[k], " midrst in_ready"}, 32'(rdy[k]), 0);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    v = 4'b0100;
    rand_data();
    step();
    step();
    check("c4 post-rst chan", 32'(oc[0]), 2);

    v = 4'hF;
    for (int n = 0; n < 6; n++) begin
      rand_data();
      step();
    end

    for (int c = 0; c < 4; c++) d[c] = 8'hA5;
    step();
    ordy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rand_data();
      step();
      check("c4 hold data", 32'(od[0]), 32'hA5);
      check("c3 hold data", 32'(od[1]), 32'hA5);
    end
    ordy = 1'b1;
    rand_data();
    step();
    step();

    v = 4'b0001;
    step();
    step();
    v = 4'b0011;
    rand_data();
    step();
    step();

    mode = 1'b0;
    sel  = 2'd3;
    v    = 4'hF;
    for (int n = 0; n < 3; n++) begin
      rand_data();
      step();
    end

    mode = 1'b1;
    v    = 4'h0;
    step();
    step();
    v = 4'hF;
    step();
    step();

    for (int n = 0; n < 300; n++) begin
      rand_data();
      v    = 4'($urandom);
      mode = 1'($urandom);
      sel  = 2'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      step();
    end

    v    = 4'h0;
    ordy = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
